// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller with stall/flush vector, multi-cycle EX sequencing
// and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int MC_W  = 6,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_from_if,
  input  logic            stallreq_from_id,
  input  logic            stallreq_from_ex,
  input  logic            ex_mc_start,
  input  logic [MC_W-1:0] ex_mc_cycles,
  input  logic            flush_req,
  output logic [5:0]      stall,
  output logic            flush,
  output logic            mc_busy,
  output logic            mc_done,
  output logic [MC_W-1:0] mc_remain,
  output logic [CNT_W-1:0] stall_cycles
);
  typedef enum logic [1:0] {IDLE, MC_BUSY, FLUSH} state_t;
  state_t          state_q, state_d;
  logic [MC_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            start_ok, long_op, mc_hold;
  always_comb begin
    start_ok = !flush_req && state_q == IDLE && ex_mc_start;
    long_op  = ex_mc_cycles > MC_W'(1);
    mc_hold  = !flush_req && ((start_ok && long_op) || (state_q == MC_BUSY && remain_q > MC_W'(1)));
    // outputs are forced low while reset is held, even though inputs may be active
    stall    = (rst || flush_req || state_q == FLUSH) ? 6'b000000 :
               (mc_hold || stallreq_from_ex)        ? 6'b001111 :
               stallreq_from_id                     ? 6'b000111 :
               stallreq_from_if                     ? 6'b000011 : 6'b000000;
    flush    = !rst && state_q == FLUSH;
    mc_busy  = !rst && state_q == MC_BUSY;
    mc_done  = !rst && ((start_ok && !long_op) ||
                        (!flush_req && state_q == MC_BUSY && remain_q == MC_W'(1)));
    state_d  = flush_req ? FLUSH : mc_hold ? MC_BUSY : IDLE;
    remain_d = flush_req                                  ? '0 :
               (start_ok && long_op)                      ? ex_mc_cycles - MC_W'(1) :
               (state_q == MC_BUSY && remain_q != '0)     ? remain_q - MC_W'(1) : '0;
    cnt_d    = (stall[0] && ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      remain_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
    end
  end
  assign mc_remain    = remain_q;
  assign stall_cycles = cnt_q;
endmodule
